// File: rtl/vend_change_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vend_change_ctrl_if : coin/inventory/payout signal bundle for vend_change_ctrl
// rev 1.0
// ----------------------------------------------------------------------------
interface vend_change_ctrl_if #(
  parameter int CNT_W    = 8,
  parameter int CREDIT_W = 6
);
  logic                nickel_in;
  logic                dime_in;
  logic                quarter_in;
  logic                load;
  logic [CNT_W-1:0]    cans;
  logic [CNT_W-1:0]    nickels;
  logic [CNT_W-1:0]    dimes;
  logic                dispense;
  logic                nickel_out;
  logic                dime_out;
  logic                coin_reject;
  logic                empty;
  logic                exact_change;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output nickel_in, dime_in, quarter_in, load, cans, nickels, dimes,
    input  dispense, nickel_out, dime_out, coin_reject, empty, exact_change, credit, busy
  );

  modport slave (
    input  nickel_in, dime_in, quarter_in, load, cans, nickels, dimes,
    output dispense, nickel_out, dime_out, coin_reject, empty, exact_change, credit, busy
  );
endinterface
`default_nettype wire

// File: rtl/vend_change_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vend_change_ctrl : credit accumulation, drink dispense and coin-by-coin change
// rev 1.0
// ----------------------------------------------------------------------------
module vend_change_ctrl #(
  parameter int PRICE_N  = 7,
  parameter int CNT_W    = 8,
  parameter int CREDIT_W = 6
) (
  input wire                clk,
  input wire                reset,
  vend_change_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_N);
  localparam logic [CNT_W-1:0]    CNT_MAX = '1;

  state_t              state;
  logic [CREDIT_W-1:0] credit;
  logic [CNT_W-1:0]    can_cnt;
  logic [CNT_W-1:0]    nickel_cnt;
  logic [CNT_W-1:0]    dime_cnt;
  logic                dispense;
  logic                nickel_out;
  logic                dime_out;
  logic                coin_reject;

  logic [1:0]          coin_count;
  logic                coin_any;
  logic                coin_multi;
  logic                coin_bad;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] credit_sum;
  logic [CREDIT_W-1:0] vend_credit;
  logic [CREDIT_W-1:0] change_credit;
  logic [CNT_W-1:0]    change_dimes;
  logic [CNT_W+1:0]    change_reach;
  logic                empty;
  logic                exact_change;

  // Coin chosen for the next payout cycle: dimes first while they still fit.
  function automatic logic pick_dime(input logic [CREDIT_W-1:0] c, input logic [CNT_W-1:0] d);
    return (c >= CREDIT_W'(2)) && (d != '0);
  endfunction

  assign coin_count = {1'b0, bus.nickel_in} + {1'b0, bus.dime_in} + {1'b0, bus.quarter_in};
  assign coin_any   = (coin_count != 2'd0);
  assign coin_multi = (coin_count > 2'd1);

  always_comb begin
    coin_val = '0;
    if (bus.nickel_in)       coin_val = CREDIT_W'(1);
    else if (bus.dime_in)    coin_val = CREDIT_W'(2);
    else if (bus.quarter_in) coin_val = CREDIT_W'(5);
  end

  assign credit_sum = credit + coin_val;
  assign coin_bad   = empty
                   || (bus.nickel_in && (nickel_cnt == CNT_MAX))
                   || (bus.dime_in && (dime_cnt == CNT_MAX))
                   || (exact_change && (credit_sum > PRICE_C));

  assign vend_credit   = credit - PRICE_C;
  assign change_credit = dime_out ? (credit - CREDIT_W'(2)) : (credit - CREDIT_W'(1));
  assign change_dimes  = dime_out ? (dime_cnt - CNT_W'(1)) : dime_cnt;

  assign change_reach = {2'b00, nickel_cnt} + {1'b0, dime_cnt, 1'b0};
  assign empty        = (can_cnt == '0);
  assign exact_change = (nickel_cnt == '0) || (change_reach < (CNT_W+2)'(4));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      can_cnt     <= '0;
      nickel_cnt  <= '0;
      dime_cnt    <= '0;
      dispense    <= 1'b0;
      nickel_out  <= 1'b0;
      dime_out    <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      dispense    <= 1'b0;
      nickel_out  <= 1'b0;
      dime_out    <= 1'b0;
      coin_reject <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load && (credit == '0)) begin
            can_cnt     <= bus.cans;
            nickel_cnt  <= bus.nickels;
            dime_cnt    <= bus.dimes;
            coin_reject <= coin_any;
          end else if (coin_multi) begin
            coin_reject <= 1'b1;
          end else if (coin_any) begin
            if (coin_bad) begin
              coin_reject <= 1'b1;
            end else begin
              credit <= credit_sum;
              if (bus.nickel_in) nickel_cnt <= nickel_cnt + CNT_W'(1);
              if (bus.dime_in)   dime_cnt   <= dime_cnt + CNT_W'(1);
              if (credit_sum >= PRICE_C) begin
                state    <= VEND;
                dispense <= 1'b1;
              end
            end
          end
        end
        VEND: begin
          coin_reject <= coin_any;
          can_cnt     <= can_cnt - CNT_W'(1);
          credit      <= vend_credit;
          if (vend_credit == '0) begin
            state <= IDLE;
          end else begin
            state      <= CHANGE;
            dime_out   <= pick_dime(vend_credit, dime_cnt);
            nickel_out <= !pick_dime(vend_credit, dime_cnt);
          end
        end
        CHANGE: begin
          // The pulse shown this cycle is the coin being paid; commit it now.
          coin_reject <= coin_any;
          credit      <= change_credit;
          if (dime_out) dime_cnt   <= dime_cnt - CNT_W'(1);
          else          nickel_cnt <= nickel_cnt - CNT_W'(1);
          if (change_credit == '0) begin
            state <= IDLE;
          end else begin
            dime_out   <= pick_dime(change_credit, change_dimes);
            nickel_out <= !pick_dime(change_credit, change_dimes);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dispense     = dispense;
  assign bus.nickel_out   = nickel_out;
  assign bus.dime_out     = dime_out;
  assign bus.coin_reject  = coin_reject;
  assign bus.empty        = empty;
  assign bus.exact_change = exact_change;
  assign bus.credit       = credit;
  assign bus.busy         = (state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_vend_change_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vend_change_ctrl : vector table, directed corner sequences and random run
// rev 1.0
// ----------------------------------------------------------------------------
module tb_vend_change_ctrl;
  localparam int PRICE   = 7;
  localparam int CNT_MAX = 255;
  localparam int P_DISP  = 0;
  localparam int P_DIME  = 1;
  localparam int P_NICK  = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  vend_change_ctrl_if #(.CNT_W(8), .CREDIT_W(6)) bus ();

  vend_change_ctrl #(.PRICE_N(PRICE), .CNT_W(8), .CREDIT_W(6)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counts as plain integers, a purchase expands into a list of payout items.
  int   m_credit, m_cans, m_nick, m_dime;
  int   plan[$];
  logic m_rej;

  typedef struct {
    logic n, d, q, ld;
    logic [7:0] c, nk, dm;
    int   cr;
    logic rj, ds, no, dout, by, em, ex;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic n, d, q, ld, input int c, nk, dm, cr,
                              input logic rj, ds, no, dout, by, em, ex);
    vec_t v;
    v.n = n; v.d = d; v.q = q; v.ld = ld;
    v.c = 8'(c); v.nk = 8'(nk); v.dm = 8'(dm);
    v.cr = cr; v.rj = rj; v.ds = ds; v.no = no; v.dout = dout;
    v.by = by; v.em = em; v.ex = ex;
    return v;
  endfunction

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic m_exact();
    return (m_nick == 0) || (m_nick + 2 * m_dime < 4);
  endfunction

  function automatic void model_reset();
    m_credit = 0; m_cans = 0; m_nick = 0; m_dime = 0; m_rej = 1'b0;
    plan.delete();
  endfunction

  function automatic void model_edge(input logic n, d, q, ld, input int c, nk, dm);
    int ncoins, val, item, rest, dl;
    ncoins = int'(n) + int'(d) + int'(q);
    val    = n ? 1 : (d ? 2 : 5);
    m_rej  = 1'b0;
    if (plan.size() > 0) begin
      m_rej = (ncoins > 0);
      item  = plan.pop_front();
      if (item == P_DISP) begin m_cans--; m_credit -= PRICE; end
      else if (item == P_DIME) begin m_dime--; m_credit -= 2; end
      else begin m_nick--; m_credit -= 1; end
    end else if (ld && m_credit == 0) begin
      m_cans = c; m_nick = nk; m_dime = dm;
      m_rej  = (ncoins > 0);
    end else if (ncoins > 1) begin
      m_rej = 1'b1;
    end else if (ncoins == 1) begin
      if (m_cans == 0 || (n && m_nick == CNT_MAX) || (d && m_dime == CNT_MAX) ||
          (m_exact() && m_credit + val > PRICE)) begin
        m_rej = 1'b1;
      end else begin
        m_credit += val;
        if (n) m_nick++;
        if (d) m_dime++;
        if (m_credit >= PRICE) begin
          plan.push_back(P_DISP);
          rest = m_credit - PRICE;
          dl   = m_dime;
          while (rest > 0) begin
            if (rest >= 2 && dl > 0) begin plan.push_back(P_DIME); dl--; rest -= 2; end
            else begin plan.push_back(P_NICK); rest -= 1; end
          end
        end
      end
    end
  endfunction

  function automatic void compare_model();
    chk("credit",       int'(bus.credit),       m_credit);
    chk("dispense",     int'(bus.dispense),     int'(plan.size() > 0 && plan[0] == P_DISP));
    chk("dime_out",     int'(bus.dime_out),     int'(plan.size() > 0 && plan[0] == P_DIME));
    chk("nickel_out",   int'(bus.nickel_out),   int'(plan.size() > 0 && plan[0] == P_NICK));
    chk("busy",         int'(bus.busy),         int'(plan.size() > 0));
    chk("coin_reject",  int'(bus.coin_reject),  int'(m_rej));
    chk("empty",        int'(bus.empty),        int'(m_cans == 0));
    chk("exact_change", int'(bus.exact_change), int'(m_exact()));
  endfunction

  task automatic step(input logic n, d, q, ld, input int c, nk, dm);
    bus.nickel_in = n; bus.dime_in = d; bus.quarter_in = q; bus.load = ld;
    bus.cans = 8'(c); bus.nickels = 8'(nk); bus.dimes = 8'(dm);
    @(posedge clk);
    model_edge(n, d, q, ld, c, nk, dm);
    #1;
    bus.nickel_in = 1'b0; bus.dime_in = 1'b0; bus.quarter_in = 1'b0; bus.load = 1'b0;
    compare_model();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; called just after a rising edge.
  task automatic mid_reset();
    #4;
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst_dispense",   int'(bus.dispense),    0);
    chk("arst_nickel_out", int'(bus.nickel_out),  0);
    chk("arst_dime_out",   int'(bus.dime_out),    0);
    chk("arst_reject",     int'(bus.coin_reject), 0);
    chk("arst_busy",       int'(bus.busy),        0);
    chk("arst_credit",     int'(bus.credit),      0);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.nickel_in = 1'b0; bus.dime_in = 1'b0; bus.quarter_in = 1'b0; bus.load = 1'b0;
    bus.cans = '0; bus.nickels = '0; bus.dimes = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_credit",   int'(bus.credit),       0);
    chk("rst_empty",    int'(bus.empty),        1);
    chk("rst_exact",    int'(bus.exact_change), 1);
    chk("rst_busy",     int'(bus.busy),         0);
    chk("rst_dispense", int'(bus.dispense),     0);
    reset = 1'b0;

    //           n  d  q  ld cans nk  dm   cr rj ds no do by em ex
    tbl.push_back(mk(0, 0, 0, 1, 5,   2,  15, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,   0,  0,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,   0,  0,  3, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,   0,  0,  8, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,   0,  0,  1, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,   0,  0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,   0,  0,  5, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,   0,  0,  10, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,   0,  0,  3, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,   0,  0,  1, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,   0,  0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3,   0,  10, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0,   0,  0,  5, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0,   0,  0,  5, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0,   0,  0,  7, 0, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0,   0,  0,  0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 2,   255, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,   0,  0,  0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,   0,  0,  2, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0,   0,  0,  2, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,   0,  0,  2, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,   0,  0,  7, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,   0,  0,  0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].n, tbl[i].d, tbl[i].q, tbl[i].ld, int'(tbl[i].c), int'(tbl[i].nk), int'(tbl[i].dm));
      chk($sformatf("vec%0d_credit", i),   int'(bus.credit),       tbl[i].cr);
      chk($sformatf("vec%0d_reject", i),   int'(bus.coin_reject),  int'(tbl[i].rj));
      chk($sformatf("vec%0d_dispense", i), int'(bus.dispense),     int'(tbl[i].ds));
      chk($sformatf("vec%0d_nickel", i),   int'(bus.nickel_out),   int'(tbl[i].no));
      chk($sformatf("vec%0d_dime", i),     int'(bus.dime_out),     int'(tbl[i].dout));
      chk($sformatf("vec%0d_busy", i),     int'(bus.busy),         int'(tbl[i].by));
      chk($sformatf("vec%0d_empty", i),    int'(bus.empty),        int'(tbl[i].em));
      chk($sformatf("vec%0d_exact", i),    int'(bus.exact_change), int'(tbl[i].ex));
    end

    // Simultaneous coins rejected; a coin offered while paying change is bounced.
    step(1, 1, 0, 0, 0, 0, 0);
    chk("dual_reject", int'(bus.coin_reject), 1);
    chk("dual_credit", int'(bus.credit),      0);
    step(0, 0, 0, 1, 5, 4, 4);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("t5_dispense", int'(bus.dispense), 1);
    idle();
    chk("t5_dime_out", int'(bus.dime_out), 1);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("t5_reject",     int'(bus.coin_reject), 1);
    chk("t5_nickel_out", int'(bus.nickel_out),  1);
    chk("t5_credit",     int'(bus.credit),      1);
    idle();
    chk("t5_done_busy", int'(bus.busy), 0);

    // Last can sold leaves the machine empty; further coins bounce.
    step(0, 0, 0, 1, 1, 4, 3);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    idle();
    idle();
    idle();
    chk("t6_empty", int'(bus.empty), 1);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("t6_reject", int'(bus.coin_reject), 1);
    chk("t6_credit", int'(bus.credit),      0);

    // Reset in the middle of a change payout.
    step(0, 0, 0, 1, 2, 4, 4);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    idle();
    chk("t6_in_change", int'(bus.dime_out), 1);
    mid_reset();
    idle();
    chk("t6_post_empty", int'(bus.empty),        1);
    chk("t6_post_exact", int'(bus.exact_change), 1);

    // Random traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r, rl, c, nk, dm;
      logic n, d, q, ld;
      r  = int'($urandom_range(0, 99));
      rl = int'($urandom_range(0, 99));
      n = 1'b0; d = 1'b0; q = 1'b0;
      if (r < 45) begin end
      else if (r < 60) n = 1'b1;
      else if (r < 75) d = 1'b1;
      else if (r < 92) q = 1'b1;
      else begin n = 1'($urandom_range(0, 1)); d = 1'b1; q = 1'($urandom_range(0, 1)); end
      ld = (rl < 5);
      c  = int'($urandom_range(0, 3));
      nk = ($urandom_range(0, 9) == 0) ? int'($urandom_range(253, 255)) : int'($urandom_range(0, 6));
      dm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(253, 255)) : int'($urandom_range(0, 6));
      step(n, d, q, ld, c, nk, dm);
      if ($urandom_range(0, 399) == 0) mid_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
